// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants and helpers for the seven-segment display driver
package seven_seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    // Active-low {dp,g,f,e,d,c,b,a}, dp always off
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;

    function automatic logic [NUM_DIGITS-1:0] col_enable(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// rtl/seven_seg_decoder.sv - combinational BCD digit to active-low segment pattern
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (code_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_top.sv
// rtl/seven_seg_top.sv - time-multiplexed 8-digit display of credit and candy count
module seven_seg_top
    import seven_seg_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            sum,
    input  logic [2:0]            candy_sum,
    output logic [NUM_DIGITS-1:0] display_column,
    output logic [7:0]            out
);

    logic [3:0]            sum_q;
    logic [2:0]            cand_q;
    logic [DIV_WIDTH-1:0]  presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] col_q, col_d;
    logic [7:0]            seg_q, seg_d;

    logic [3:0] d0_code;
    logic       d1_blank;
    logic [3:0] dig_code;
    logic       dig_blank;

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = (&presc_q) ? idx_q + 1'b1 : idx_q;
    end

    // Binary-to-BCD for 0..15: tens digit is either blank or 1
    always_comb begin
        d0_code  = sum_q;
        d1_blank = 1'b1;
        if (sum_q >= 4'd10) begin
            d0_code  = sum_q - 4'd10;
            d1_blank = 1'b0;
        end
    end

    always_comb begin
        dig_code  = 4'd0;
        dig_blank = 1'b1;
        case (idx_q)
            3'd0: begin
                dig_code  = d0_code;
                dig_blank = 1'b0;
            end
            3'd1: begin
                dig_code  = 4'd1;
                dig_blank = d1_blank;
            end
            3'd4: begin
                dig_code  = {1'b0, cand_q};
                dig_blank = 1'b0;
            end
            default: ;
        endcase
    end

    seven_seg_decoder u_decoder (
        .code_i  (dig_code),
        .blank_i (dig_blank),
        .seg_o   (seg_d)
    );

    // Column and segments both derive from idx_q so they switch on the same edge
    assign col_d = col_enable(idx_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q   <= 4'd0;
            cand_q  <= 3'd0;
            presc_q <= '0;
            idx_q   <= '0;
            col_q   <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            sum_q   <= sum;
            cand_q  <= candy_sum;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            seg_q   <= seg_d;
        end
    end

    assign display_column = col_q;
    assign out            = seg_q;

endmodule

// File: tb/tb_seven_seg_top.sv
// tb/tb_seven_seg_top.sv - self-checking bench for seven_seg_top with DIV_WIDTH=2
module tb_seven_seg_top;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sum;
    logic [2:0] candy_sum;
    logic [7:0] display_column;
    logic [7:0] out;

    int vectors    = 0;
    int miscompares = 0;

    seven_seg_top #(.DIV_WIDTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .sum            (sum),
        .candy_sum      (candy_sum),
        .display_column (display_column),
        .out            (out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int v);
        logic [7:0] p [10];
        p = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return p[v];
    endfunction

    function automatic logic [7:0] model_digit(input int idx, input int s, input int c);
        case (idx)
            0:       return pat(s % 10);
            1:       return (s >= 10) ? pat(s / 10) : 8'hFF;
            4:       return pat(c);
            default: return 8'hFF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level reference: expectation pushed at each rising edge, compared at the next falling edge
    logic [15:0] exp_q [$];
    int m_presc, m_idx, m_sum, m_cand;

    always @(posedge clk) begin
        if (reset) begin
            exp_q.push_back(16'hFFFF);
            m_presc <= 0;
            m_idx   <= 0;
            m_sum   <= 0;
            m_cand  <= 0;
        end else begin
            exp_q.push_back({~(8'h01 << m_idx), model_digit(m_idx, m_sum, m_cand)});
            m_sum   <= int'(sum);
            m_cand  <= int'(candy_sum);
            m_presc <= (m_presc + 1) % 4;
            if (m_presc == 3) m_idx <= (m_idx + 1) % 8;
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_col", display_column, e[15:8]);
            chk("sb_out", out, e[7:0]);
        end
    end

    typedef struct {
        logic [3:0] s;
        logic [2:0] c;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e4;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [7:0] prev_col;
        int         found;
        int         dig;
        logic [7:0] e;

        tbl[0] = '{4'd7,  3'd3, 8'hF8, 8'hFF, 8'hB0};
        tbl[1] = '{4'd15, 3'd5, 8'h92, 8'hF9, 8'h92};
        tbl[2] = '{4'd10, 3'd0, 8'hC0, 8'hF9, 8'hC0};
        tbl[3] = '{4'd0,  3'd7, 8'hC0, 8'hFF, 8'hF8};
        tbl[4] = '{4'd9,  3'd1, 8'h90, 8'hFF, 8'hF9};
        tbl[5] = '{4'd13, 3'd6, 8'hB0, 8'hF9, 8'h82};
        tbl[6] = '{4'd12, 3'd4, 8'hA4, 8'hF9, 8'h99};
        tbl[7] = '{4'd14, 3'd2, 8'h99, 8'hF9, 8'hA4};

        reset     = 1'b1;
        sum       = 4'd0;
        candy_sum = 3'd0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_col", display_column, 8'hFF);
        chk("reset_out", out, 8'hFF);
        reset = 1'b0;

        // Scan order: each column held 4 clocks, wrapping back to FE
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            chk($sformatf("scan_col_%0d", k), display_column, ~(8'h01 << ((k / 4) % 8)));
            if (k == 0) chk("first_out", out, 8'hC0);
        end

        foreach (tbl[v]) begin
            sum       = tbl[v].s;
            candy_sum = tbl[v].c;
            repeat (40) @(negedge clk);
            for (int k = 0; k < 32; k++) begin
                @(negedge clk);
                dig = -1;
                for (int j = 0; j < 8; j++) if (display_column == ~(8'h01 << j)) dig = j;
                if (dig < 0) begin
                    chk($sformatf("tbl%0d_onehot", v), display_column, 8'hFE);
                end else begin
                    e = (dig == 0) ? tbl[v].e0 : (dig == 1) ? tbl[v].e1 : (dig == 4) ? tbl[v].e4 : 8'hFF;
                    chk($sformatf("tbl%0d_d%0d", v, dig), out, e);
                end
            end
        end

        // Input-to-output latency on the selected digit
        sum       = 4'd2;
        candy_sum = 3'd0;
        repeat (40) @(negedge clk);
        prev_col = display_column;
        found    = 0;
        for (int t = 0; t < 100 && found == 0; t++) begin
            @(negedge clk);
            if (display_column == 8'hFE && prev_col != 8'hFE) found = 1;
            prev_col = display_column;
        end
        if (found == 0) begin
            chk("lat_wait_timeout", display_column, 8'hFE);
            chk("lat_wait_timeout_flag", 8'h00, 8'h01);
        end else begin
            chk("lat_start", out, 8'hA4);
            sum = 4'd9;
            @(negedge clk);
            chk("lat_1clk_out", out, 8'hA4);
            @(negedge clk);
            chk("lat_2clk_out", out, 8'h90);
            chk("lat_2clk_col", display_column, 8'hFE);
        end

        // Random traffic checked cycle by cycle against the reference
        for (int r = 0; r < 10; r++) begin
            sum       = 4'($urandom_range(0, 9));
            candy_sum = 3'($urandom_range(0, 9));
            #50;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_col", display_column, 8'hFF);
        chk("midreset_out", out, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_midreset_col", display_column, 8'hFE);
        chk("post_midreset_out", out, 8'hC0);
        for (int r = 0; r < 10; r++) begin
            sum       = 4'($urandom_range(0, 15));
            candy_sum = 3'($urandom_range(0, 7));
            repeat (8) @(negedge clk);
        end
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
